// File: rtl/lc3_mem_sub.sv
// lc3_mem_sub: unified instruction/data memory for the LC3 core.
// A single-port word array is shared by the fetch and data paths. An arbiter
// FSM accepts one request at a time, waits a per-path latency, then performs
// the access and pulses the matching completion output for one cycle.
//
// State table:
//   IDLE   | waiting for a request; grants fetch or data access
//   I_BUSY | instruction access in flight, counting down IMEM_LAT
//   D_BUSY | data access in flight, counting down DMEM_LAT
//   DONE   | one-cycle turnaround after a completion, nothing accepted
//
// Ports:
//   clk, rst (sync, active-low)
//   instrmem_rd, PC                          fetch request and address
//   Data_req, Data_rd, Data_addr, Data_din   data request (rd=1 read, 0 write)
//   load_en, load_addr, load_data            backdoor preload, independent of rst
//   Instr_dout, complete_instr               fetched word and its completion pulse
//   Data_dout, complete_data                 read word and data completion pulse
module lc3_mem_sub #(
    parameter int ADDR_W   = 8,
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instrmem_rd,
    input  logic [15:0] PC,
    input  logic        Data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    output logic [15:0] Data_dout,
    output logic        complete_data
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    counter, counter_nxt;
    logic                instr_pri, instr_pri_nxt;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
    logic                lat_rd, lat_rd_nxt;
    logic [15:0]         lat_din, lat_din_nxt;
    logic                finish;
    logic                wr_en;

    logic [15:0] mem [0:(2**ADDR_W)-1];

    // Upper address bits are intentionally dropped, so the array aliases.
    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^{PC[15:ADDR_W], Data_addr[15:ADDR_W], load_addr[15:ADDR_W]};
        end
    endgenerate

    always_comb begin
        state_nxt     = state;
        counter_nxt   = counter;
        instr_pri_nxt = instr_pri;
        lat_addr_nxt  = lat_addr;
        lat_rd_nxt    = lat_rd;
        lat_din_nxt   = lat_din;
        finish        = 1'b0;
        case (state)
            IDLE: begin
                // Data wins a tie unless a fetch lost the previous tie.
                if (Data_req && !(instrmem_rd && instr_pri)) begin
                    state_nxt    = D_BUSY;
                    counter_nxt  = CNT_W'(DMEM_LAT - 1);
                    lat_addr_nxt = Data_addr[ADDR_W-1:0];
                    lat_rd_nxt   = Data_rd;
                    lat_din_nxt  = Data_din;
                    if (instrmem_rd) begin
                        instr_pri_nxt = 1'b1;
                    end
                end else if (instrmem_rd) begin
                    state_nxt     = I_BUSY;
                    counter_nxt   = CNT_W'(IMEM_LAT - 1);
                    lat_addr_nxt  = PC[ADDR_W-1:0];
                    instr_pri_nxt = 1'b0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (counter == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    counter_nxt = counter - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr_en = finish && (state == D_BUSY) && !lat_rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            counter        <= '0;
            instr_pri      <= 1'b0;
            lat_addr       <= '0;
            lat_rd         <= 1'b0;
            lat_din        <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            Instr_dout     <= 16'h0000;
            Data_dout      <= 16'h0000;
        end else begin
            state          <= state_nxt;
            counter        <= counter_nxt;
            instr_pri      <= instr_pri_nxt;
            lat_addr       <= lat_addr_nxt;
            lat_rd         <= lat_rd_nxt;
            lat_din        <= lat_din_nxt;
            complete_instr <= finish && (state == I_BUSY);
            complete_data  <= finish && (state == D_BUSY);
            if (finish && (state == I_BUSY)) begin
                Instr_dout <= mem[lat_addr];
            end
            if (finish && (state == D_BUSY) && lat_rd) begin
                Data_dout <= mem[lat_addr];
            end
        end
    end

    // Array has no reset. The preload is placed last so it overrides a
    // completing write to the same word on the same edge.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[lat_addr] <= lat_din;
        end
        if (load_en) begin
            mem[load_addr[ADDR_W-1:0]] <= load_data;
        end
    end

endmodule
